// File: rtl/systolic_tile_ctrl.sv
// Sequencer for an N x N systolic MAC tile: clear, feed, skew flush, row drain, repeated per tile.
// Optional TILE_CTRL_ABORT_EN macro adds an abort input that clears the array and returns to IDLE.
module systolic_tile_ctrl #(
  parameter int ARRAY_DIM = 4,
  parameter int K_W       = 8,
  parameter int T_W       = 8,
  localparam int RW       = $clog2(ARRAY_DIM)
) (
  input  logic           clk,
  input  logic           rst,
`ifdef TILE_CTRL_ABORT_EN
  input  logic           abort,
`endif
  input  logic           start,
  input  logic [K_W-1:0] cfg_k,
  input  logic [T_W-1:0] cfg_tiles,
  output logic           mac_clear,
  output logic           feed_valid,
  output logic [K_W-1:0] feed_k_idx,
  output logic [T_W-1:0] tile_idx,
  output logic           drain_valid,
  input  logic           drain_ready,
  output logic [RW-1:0]  drain_row,
  output logic           busy,
  output logic           done
);

  // The last operand enters PE(0,0) and needs 2*(N-1) hops plus one register stage to land in PE(N-1,N-1).
  localparam int FLUSH_LEN = 2 * (ARRAY_DIM - 1) + 1;
  localparam int FW        = $clog2(FLUSH_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [K_W-1:0] cfg_k_q;
  logic [T_W-1:0] cfg_tiles_q;
  logic [K_W-1:0] k_cnt_q;
  logic [FW-1:0]  flush_cnt_q;
  logic [RW-1:0]  row_q;
  logic [T_W-1:0] tile_q;

  logic           k_last;
  logic           flush_last;
  logic           row_last;
  logic           more_tiles;
  logic           abort_go;
  logic           abort_q;

  assign k_last     = (k_cnt_q == cfg_k_q - K_W'(1));
  assign flush_last = (flush_cnt_q == FW'(FLUSH_LEN - 1));
  assign row_last   = (row_q == RW'(ARRAY_DIM - 1));
  assign more_tiles = (({1'b0, tile_q} + (T_W + 1)'(1)) < {1'b0, cfg_tiles_q});

`ifdef TILE_CTRL_ABORT_EN
  assign abort_go = abort && (state_q != S_IDLE);

  // Remembers that the CLEAR in progress came from an abort, so it exits to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_go;
    end
  end
`else
  assign abort_go = 1'b0;
  assign abort_q  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (cfg_tiles == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (abort_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = (cfg_k_q == '0) ? S_FLUSH : S_FEED;
        end
      end
      S_FEED: begin
        if (k_last) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_ready && row_last) begin
          state_d = more_tiles ? S_CLEAR : S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_go) state_d = S_CLEAR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_k_q     <= '0;
      cfg_tiles_q <= '0;
      k_cnt_q     <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      tile_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cfg_k_q     <= cfg_k;
            cfg_tiles_q <= cfg_tiles;
            tile_q      <= '0;
          end
        end
        S_CLEAR: begin
          k_cnt_q     <= '0;
          flush_cnt_q <= '0;
          row_q       <= '0;
        end
        S_FEED: begin
          k_cnt_q <= k_cnt_q + K_W'(1);
        end
        S_FLUSH: begin
          flush_cnt_q <= flush_cnt_q + FW'(1);
        end
        S_DRAIN: begin
          if (drain_ready) begin
            row_q <= row_q + RW'(1);
            if (row_last && more_tiles) tile_q <= tile_q + T_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Moore outputs: indices read as zero outside the states that own them.
  assign mac_clear   = (state_q == S_CLEAR);
  assign feed_valid  = (state_q == S_FEED);
  assign feed_k_idx  = (state_q == S_FEED) ? k_cnt_q : '0;
  assign drain_valid = (state_q == S_DRAIN);
  assign drain_row   = (state_q == S_DRAIN) ? row_q : '0;
  assign tile_idx    = tile_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Scoreboard bench for systolic_tile_ctrl: a run-level model predicts the event stream, a monitor compares it.
// Build with TILE_CTRL_ABORT_EN defined to also exercise the abort port.
module tb_systolic_tile_ctrl;

  localparam int N         = 4;
  localparam int K_W       = 8;
  localparam int T_W       = 8;
  localparam int FLUSH_LEN = 2 * (N - 1) + 1;

  localparam logic [3:0] K_START = 4'd1;
  localparam logic [3:0] K_CLR   = 4'd2;
  localparam logic [3:0] K_FEED  = 4'd3;
  localparam logic [3:0] K_ROW   = 4'd4;
  localparam logic [3:0] K_DONE  = 4'd5;

  typedef struct packed {
    logic [3:0]  kind;
    logic [7:0]  a;
    logic [7:0]  t;
    logic [11:0] gap;
  } tok_t;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic [K_W-1:0]         cfg_k;
  logic [T_W-1:0]         cfg_tiles;
  logic                   mac_clear;
  logic                   feed_valid;
  logic [K_W-1:0]         feed_k_idx;
  logic [T_W-1:0]         tile_idx;
  logic                   drain_valid;
  logic                   drain_ready;
  logic [$clog2(N)-1:0]   drain_row;
  logic                   busy;
  logic                   done;
`ifdef TILE_CTRL_ABORT_EN
  logic                   abort;
`endif

  tok_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  systolic_tile_ctrl #(.ARRAY_DIM(N), .K_W(K_W), .T_W(T_W)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef TILE_CTRL_ABORT_EN
    .abort      (abort),
`endif
    .start      (start),
    .cfg_k      (cfg_k),
    .cfg_tiles  (cfg_tiles),
    .mac_clear  (mac_clear),
    .feed_valid (feed_valid),
    .feed_k_idx (feed_k_idx),
    .tile_idx   (tile_idx),
    .drain_valid(drain_valid),
    .drain_ready(drain_ready),
    .drain_row  (drain_row),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic tok_t mk(input logic [3:0] kind, input int a, input int t, input int gap);
    tok_t r;
    r.kind = kind;
    r.a    = 8'(a);
    r.t    = 8'(t);
    r.gap  = 12'(gap);
    return r;
  endfunction

  // Run-level model: gap is the number of non-stalled busy cycles since the previous event.
  task automatic push_model(input int k, input int tiles);
    exp_q.push_back(mk(K_START, 0, 0, 1));
    for (int t = 0; t < tiles; t++) begin
      exp_q.push_back(mk(K_CLR, 0, t, 1));
      for (int i = 0; i < k; i++) exp_q.push_back(mk(K_FEED, i, t, 1));
      for (int r = 0; r < N; r++) exp_q.push_back(mk(K_ROW, r, t, (r == 0) ? FLUSH_LEN + 1 : 1));
    end
    exp_q.push_back(mk(K_DONE, 0, 0, 1));
  endtask

  function automatic int done_cycle(input int k, input int tiles);
    return (tiles == 0) ? -1 : tiles * (1 + k + FLUSH_LEN + N) + 1;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: turns each observable DUT event into a token and compares with the model queue.
  initial begin
    int   gap_cnt;
    bit   have;
    tok_t cur;
    tok_t e;
    gap_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        gap_cnt = 0;
      end else begin
        have = 1'b1;
        if (start && !busy)                 cur = mk(K_START, 0, 0, 0);
        else if (mac_clear)                 cur = mk(K_CLR, 0, int'(tile_idx), 0);
        else if (feed_valid)                cur = mk(K_FEED, int'(feed_k_idx), int'(tile_idx), 0);
        else if (drain_valid && drain_ready) cur = mk(K_ROW, int'(drain_row), int'(tile_idx), 0);
        else if (done)                      cur = mk(K_DONE, 0, 0, 0);
        else                                have = 1'b0;
        if (have) begin
          cur.gap = 12'(gap_cnt + 1);
          gap_cnt = 0;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d a=%0d tile=%0d gap=%0d, required no event",
                     cur.kind, cur.a, cur.t, cur.gap);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              n_fail++;
              $display("FAIL event_stream: got kind=%0d a=%0d tile=%0d gap=%0d, required kind=%0d a=%0d tile=%0d gap=%0d",
                       cur.kind, cur.a, cur.t, cur.gap, e.kind, e.a, e.t, e.gap);
            end
          end
        end else if (busy && !(drain_valid && !drain_ready)) begin
          gap_cnt++;
        end
      end
    end
  end

  // mode 0: always ready; 1: random ready, stray starts; 2: hold ready low 5 cycles at row 2.
  task automatic run_test(input int k, input int tiles, input int mode, input int exp_lat);
    int cyc;
    int lat;
    int stall;
    @(posedge clk); #1;
    start       = 1'b1;
    cfg_k       = K_W'(k);
    cfg_tiles   = T_W'(tiles);
    drain_ready = 1'b1;
    push_model(k, tiles);
    cyc   = 0;
    lat   = -1;
    stall = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (done && lat < 0) lat = cyc;
      cfg_k     = K_W'($urandom);
      cfg_tiles = T_W'($urandom);
      case (mode)
        1: begin
          drain_ready = ($urandom_range(0, 3) != 0);
          start       = ($urandom_range(0, 7) == 0) && busy;
        end
        2: begin
          if (drain_valid && drain_row == 2 && stall < 5) begin
            drain_ready = 1'b0;
            stall++;
          end else begin
            drain_ready = 1'b1;
          end
        end
        default: drain_ready = 1'b1;
      endcase
    end
    start       = 1'b0;
    drain_ready = 1'b1;
    if (exp_q.size() != 0) begin
      check("run_timeout_pending_events", exp_q.size(), 0);
      exp_q.delete();
    end
    if (exp_lat >= 0) check("done_cycle", lat, exp_lat);
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_run", int'(busy), 0);
  endtask

  initial begin
    int  found;
    rst         = 1'b1;
    start       = 1'b0;
    cfg_k       = '0;
    cfg_tiles   = '0;
    drain_ready = 1'b1;
`ifdef TILE_CTRL_ABORT_EN
    abort       = 1'b0;
`endif
    #12;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_outputs", int'({mac_clear, feed_valid, drain_valid}), 0);
    check("reset_indices", int'(feed_k_idx) + int'(drain_row) + int'(tile_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_test(3, 1, 0, done_cycle(3, 1));
    run_test(3, 1, 2, done_cycle(3, 1) + 5);
    run_test(2, 3, 0, done_cycle(2, 3));
    run_test(2, 3, 1, -1);
    run_test(0, 1, 0, done_cycle(0, 1));
    run_test(0, 0, 0, -1);
    run_test(1, 2, 2, done_cycle(1, 2) + 5);
    for (int r = 0; r < 8; r++) begin
      run_test($urandom_range(0, 5), $urandom_range(0, 3), 1, -1);
    end

    // Asynchronous reset in the middle of FEED.
    @(posedge clk); #1;
    start     = 1'b1;
    cfg_k     = 8'd6;
    cfg_tiles = 8'd2;
    push_model(6, 2);
    found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (feed_valid && feed_k_idx == 8'd2) found = 1;
    end
    check("reach_mid_feed", found, 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_feed_valid", int'(feed_valid), 0);
    check("async_rst_feed_idx", int'(feed_k_idx), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_test(2, 1, 0, done_cycle(2, 1));

`ifdef TILE_CTRL_ABORT_EN
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_in_idle_ignored", int'(busy), 0);
    start     = 1'b1;
    cfg_k     = 8'd2;
    cfg_tiles = 8'd1;
    exp_q.push_back(mk(K_START, 0, 0, 1));
    exp_q.push_back(mk(K_CLR, 0, 0, 1));
    exp_q.push_back(mk(K_FEED, 0, 0, 1));
    exp_q.push_back(mk(K_FEED, 1, 0, 1));
    exp_q.push_back(mk(K_ROW, 0, 0, FLUSH_LEN + 1));
    exp_q.push_back(mk(K_CLR, 0, 0, 1));
    found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (drain_valid && drain_row == 1) found = 1;
    end
    check("reach_drain_row1", found, 1);
    abort       = 1'b1;
    drain_ready = 1'b0;
    @(posedge clk); #1;
    abort       = 1'b0;
    drain_ready = 1'b1;
    check("abort_clear", int'(mac_clear), 1);
    @(posedge clk); #1;
    check("abort_idle", int'(busy), 0);
    check("abort_no_done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_events_left", exp_q.size(), 0);
    exp_q.delete();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
